array_update_arbiter: RTL and testbench
=======================================

Name: array_update_arbiter

Overview:
- Owns a NUM_ELEMS x ELEM_W array state register and shares its single array-update write port among NUM_REQ requesters.
- Each requester issues (index, value) updates over valid/ready.
- A round-robin arbiter grants one update per cycle into a 2-stage pipeline: grant register, then array_update.
- The full array is exported flattened, element 0 in the LSBs, for downstream XLS-generated pipelines.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- NUM_ELEMS, 4, array depth.
- ELEM_W, 33, element width in bits.
- IDX_W, 32, index width per requester (u32 index semantics).

Ports:
- clk  input  1  clock; all state on posedge.
- rst  input  1  asynchronous, active-high reset.
- stall  input  1  when 1, all req_ready forced 0; in-flight updates still complete.
- req_valid  input  NUM_REQ  per-requester update valid.
- req_ready  output  NUM_REQ  per-requester grant/accept; one-hot or zero.
- req_index  input  NUM_REQ*IDX_W  flattened indices; requester i at [i*IDX_W +: IDX_W].
- req_value  input  NUM_REQ*ELEM_W  flattened values; requester i at [i*ELEM_W +: ELEM_W].
- arr_out  output  NUM_ELEMS*ELEM_W  current array; element k at [k*ELEM_W +: ELEM_W].
- upd_valid  output  1  pulses the cycle an update is applied (including no-op out-of-range updates).
- upd_src  output  clog2(NUM_REQ)  requester whose update is applied when upd_valid=1; 0 otherwise.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - All array elements = 0, so arr_out = 0.
  - RR pointer = 0; stage-1 valid = 0; upd_valid = 0; upd_src = 0.
  - req_ready = 0 while rst = 1.
- Arbitration (combinational):
  - If stall = 0, grant the first i with req_valid[i] = 1, scanning from the RR pointer upward with wrap-around.
  - req_ready[i] = 1 only for the granted i. req_ready may depend on req_valid; requesters must not depend on req_ready to raise valid.
  - Accept = req_valid[i] & req_ready[i].
  - On accept from i: pointer <= (i+1) mod NUM_REQ. No accept: pointer holds.
- Stage 1 (cycle T+1 after accept at T): register index, value and source, and set s1_valid.
- Stage 2 (edge ending T+1): if s1_valid, array[index] <= value.
  - Index >= NUM_ELEMS: array unchanged (XLS array_update out-of-bounds no-op).
  - upd_valid = 1 and upd_src = source during cycle T+1; arr_out shows the new value from cycle T+2.
- Latency: accept at T, visible on arr_out at T+2.
- Throughput: one update per cycle, fully pipelined, no bubbles.
- Ordering: updates apply in accept order. Back-to-back writes to the same index leave the later value.
- Stall:
  - Affects acceptance only. An update accepted in the cycle before stall rises still applies.
  - Pointer holds during stall.
- Reset mid-operation: the in-flight stage-1 update is discarded and the array returns to 0.
- Unused index high bits take part in the range compare. Any nonzero bit at or above clog2(NUM_ELEMS) counts as out of range when NUM_ELEMS is a power of 2.

Optional Feature:
- ARRAY_UPDATE_OOB_ERR_EN defined: adds output oob_err (1 bit) and oob_src (clog2(NUM_REQ)).
  - oob_err is a sticky flag, set in the cycle an out-of-range update is applied (same cycle as upd_valid).
  - oob_src captures the source of the first offender.
  - Both are cleared only by rst.
- Not defined: ports and logic absent; out-of-range updates are silent no-ops.

Test Plan:
- Reset: hold rst = 1 with all req_valid = 1 -> req_ready = 0, arr_out = 0. Deassert -> first grant to requester 0.
- Single update: req 2 sends index 1, value 42 at T -> upd_valid = 1 and upd_src = 2 at T+1; from T+2 arr_out[65:33] = 42, other elements 0.
- Round-robin: all 4 valid continuously for 8 cycles -> grants 0,1,2,3,0,1,2,3, one-hot req_ready each cycle.
- Same-index hazard: req 0 writes index 3 = 5 at T, req 1 writes index 3 = 7 at T+1 -> element 3 = 5 at T+2, then 7 at T+3.
- Out-of-range: req 1 sends index 4, value 0x1FFFFFFFF -> upd_valid pulses, arr_out unchanged. With ARRAY_UPDATE_OOB_ERR_EN: oob_err = 1 and oob_src = 1, persisting until rst.
- Stall/reset mid-flight: accept at T, stall = 1 at T+1 -> update still lands at T+2 and no further accepts. Separately, assert rst at T+1 after an accept at T -> arr_out = 0 and no upd_valid.

Source files
------------

// File: rtl/array_update_arbiter.sv
// Round-robin arbiter sharing one array-update write port among NUM_REQ requesters.
// Optional ARRAY_UPDATE_OOB_ERR_EN adds sticky out-of-range error reporting (oob_err, oob_src).
module array_update_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int NUM_ELEMS = 4,
    parameter int ELEM_W    = 33,
    parameter int IDX_W     = 32,
    localparam int SRC_W    = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          stall,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*IDX_W-1:0]      req_index,
    input  logic [NUM_REQ*ELEM_W-1:0]     req_value,
    output logic [NUM_ELEMS*ELEM_W-1:0]   arr_out,
    output logic                          upd_valid,
`ifdef ARRAY_UPDATE_OOB_ERR_EN
    output logic [SRC_W-1:0]              upd_src,
    output logic                          oob_err,
    output logic [SRC_W-1:0]              oob_src
`else
    output logic [SRC_W-1:0]              upd_src
`endif
);

    logic [SRC_W-1:0]  rr_ptr;
    logic              found;
    logic [SRC_W-1:0]  grant_idx;
    logic [IDX_W-1:0]  sel_index;
    logic [ELEM_W-1:0] sel_value;

    logic              s1_valid;
    logic [IDX_W-1:0]  s1_index;
    logic [ELEM_W-1:0] s1_value;
    logic [SRC_W-1:0]  s1_src;
    logic              s1_in_range;

    logic [ELEM_W-1:0] arr [NUM_ELEMS];

    // Two passes give the wrap-around scan: pointer upward first, then the indices below it.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        req_ready = '0;
        sel_index = '0;
        sel_value = '0;
        if (!rst && !stall) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && req_valid[i] && (i >= int'(rr_ptr))) begin
                    found     = 1'b1;
                    grant_idx = SRC_W'(i);
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!found && req_valid[i] && (i < int'(rr_ptr))) begin
                    found     = 1'b1;
                    grant_idx = SRC_W'(i);
                end
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (found && (grant_idx == SRC_W'(i))) begin
                req_ready[i] = 1'b1;
                sel_index    = req_index[i*IDX_W +: IDX_W];
                sel_value    = req_value[i*ELEM_W +: ELEM_W];
            end
        end
    end

    // Full-width compare so any stray high index bit is out of range.
    assign s1_in_range = (s1_index < IDX_W'(NUM_ELEMS));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr   <= '0;
            s1_valid <= 1'b0;
            s1_index <= '0;
            s1_value <= '0;
            s1_src   <= '0;
            for (int k = 0; k < NUM_ELEMS; k++) begin
                arr[k] <= '0;
            end
        end else begin
            s1_valid <= found;
            if (found) begin
                rr_ptr   <= (grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : grant_idx + SRC_W'(1);
                s1_index <= sel_index;
                s1_value <= sel_value;
                s1_src   <= grant_idx;
            end
            if (s1_valid && s1_in_range) begin
                for (int k = 0; k < NUM_ELEMS; k++) begin
                    if (s1_index == IDX_W'(k)) begin
                        arr[k] <= s1_value;
                    end
                end
            end
        end
    end

    genvar gk;
    generate
        for (gk = 0; gk < NUM_ELEMS; gk++) begin : g_pack
            assign arr_out[gk*ELEM_W +: ELEM_W] = arr[gk];
        end
    endgenerate

    assign upd_valid = s1_valid;
    assign upd_src   = s1_valid ? s1_src : '0;

`ifdef ARRAY_UPDATE_OOB_ERR_EN
    logic             oob_flag;
    logic [SRC_W-1:0] oob_src_q;
    logic             oob_now;

    assign oob_now = s1_valid && !s1_in_range;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oob_flag  <= 1'b0;
            oob_src_q <= '0;
        end else if (oob_now && !oob_flag) begin
            oob_flag  <= 1'b1;
            oob_src_q <= s1_src;
        end
    end

    // The flag must read 1 in the same cycle the offending update is applied.
    assign oob_err = oob_flag | oob_now;
    assign oob_src = oob_flag ? oob_src_q : (oob_now ? s1_src : '0);
`endif

endmodule

// File: tb/tb_array_update_arbiter.sv
// Bench for array_update_arbiter: directed plan steps, then random traffic against a reference model.
module tb_array_update_arbiter;
    localparam int NR = 4;
    localparam int NE = 4;
    localparam int EW = 33;
    localparam int IW = 32;
    localparam int SW = 2;
    localparam int CW = NE*EW;

    logic            clk = 1'b0;
    logic            rst;
    logic            stall;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [NR*IW-1:0] req_index;
    logic [NR*EW-1:0] req_value;
    logic [NE*EW-1:0] arr_out;
    logic            upd_valid;
    logic [SW-1:0]   upd_src;
`ifdef ARRAY_UPDATE_OOB_ERR_EN
    logic            oob_err;
    logic [SW-1:0]   oob_src;
`endif

    array_update_arbiter #(.NUM_REQ(NR), .NUM_ELEMS(NE), .ELEM_W(EW), .IDX_W(IW)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_index(req_index), .req_value(req_value),
        .arr_out(arr_out), .upd_valid(upd_valid),
`ifdef ARRAY_UPDATE_OOB_ERR_EN
        .upd_src(upd_src), .oob_err(oob_err), .oob_src(oob_src)
`else
        .upd_src(upd_src)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: array contents, RR pointer, one in-flight update, sticky error.
    logic [EW-1:0] m_arr [NE];
    int            m_ptr;
    bit            p_v;
    logic [IW-1:0] p_idx;
    logic [EW-1:0] p_val;
    int            p_src;
    bit            m_oob;
    int            m_oob_src;

    task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < NE; k++) m_arr[k] = '0;
        m_ptr = 0; p_v = 0; p_idx = '0; p_val = '0; p_src = 0;
        m_oob = 0; m_oob_src = 0;
    endtask

    function automatic int model_grant();
        if (rst || stall) return -1;
        for (int k = 0; k < NR; k++) begin
            int i;
            i = (m_ptr + k) % NR;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input logic [IW-1:0] idx, input logic [EW-1:0] val);
        req_valid[i] = 1'b1;
        req_index[i*IW +: IW] = idx;
        req_value[i*EW +: EW] = val;
    endtask

    // Called just after a negedge with inputs already driven; returns at the next negedge.
    task automatic do_cycle();
        int g;
        logic [CW-1:0] exp_arr;
        logic [NR-1:0] exp_rdy;
        bit p_oob;
        #1;
        if (rst) model_clear();
        g = model_grant();
        exp_rdy = (g >= 0) ? (NR'(1) << g) : '0;
        for (int k = 0; k < NE; k++) exp_arr[k*EW +: EW] = m_arr[k];
        p_oob = p_v && (p_idx >= NE);
        check("req_ready", CW'(req_ready), CW'(exp_rdy));
        check("upd_valid", CW'(upd_valid), CW'(p_v));
        check("upd_src", CW'(upd_src), p_v ? CW'(p_src) : '0);
        check("arr_out", arr_out, exp_arr);
`ifdef ARRAY_UPDATE_OOB_ERR_EN
        check("oob_err", CW'(oob_err), CW'(m_oob | p_oob));
        check("oob_src", CW'(oob_src), m_oob ? CW'(m_oob_src) : (p_oob ? CW'(p_src) : '0));
`endif
        @(posedge clk);
        if (!rst) begin
            if (p_v && p_idx < NE) m_arr[p_idx] = p_val;
            if (p_oob && !m_oob) begin
                m_oob = 1;
                m_oob_src = p_src;
            end
            p_v = (g >= 0);
            if (g >= 0) begin
                p_idx = req_index[g*IW +: IW];
                p_val = req_value[g*EW +: EW];
                p_src = g;
                m_ptr = (g + 1) % NR;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [CW-1:0] saved;
        int r;
        model_clear();
        rst = 1'b1; stall = 1'b0; req_valid = '1;
        for (int i = 0; i < NR; i++) begin
            req_index[i*IW +: IW] = IW'(i);
            req_value[i*EW +: EW] = {1'b1, $urandom};
        end
        @(negedge clk);
        do_cycle();
        do_cycle();

        // Reset release with everyone valid: strict 0,1,2,3 rotation.
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < NR; i++) set_req(i, IW'($urandom_range(0, 3)), {1'b0, $urandom});
            #1;
            check("rr_grant", CW'(req_ready), CW'(NR'(1) << (c % NR)));
            do_cycle();
        end
        req_valid = '0;
        do_cycle();
        do_cycle();

        // Single update into a freshly reset array.
        rst = 1'b1; do_cycle(); rst = 1'b0;
        set_req(2, 32'd1, 33'd42);
        do_cycle();
        req_valid = '0;
        check("single_upd_valid", CW'(upd_valid), CW'(1));
        check("single_upd_src", CW'(upd_src), CW'(2));
        do_cycle();
        check("single_arr", arr_out, CW'(33'd42) << EW);

        // Same-index hazard: later write wins.
        set_req(0, 32'd3, 33'd5);
        do_cycle();
        req_valid = '0;
        set_req(1, 32'd3, 33'd7);
        do_cycle();
        req_valid = '0;
        check("hazard_first", CW'(arr_out[3*EW +: EW]), CW'(5));
        do_cycle();
        check("hazard_second", CW'(arr_out[3*EW +: EW]), CW'(7));
        saved = arr_out;

        // Out-of-range updates are no-ops but still pulse upd_valid.
        set_req(1, 32'd4, 33'h1_FFFF_FFFF);
        do_cycle();
        req_valid = '0;
        check("oob_upd_valid", CW'(upd_valid), CW'(1));
`ifdef ARRAY_UPDATE_OOB_ERR_EN
        check("oob_err_first", CW'(oob_err), CW'(1));
        check("oob_src_first", CW'(oob_src), CW'(1));
`endif
        set_req(3, 32'h8000_0001, 33'h0_1234_5678);
        do_cycle();
        req_valid = '0;
        do_cycle();
        check("oob_arr_unchanged", arr_out, saved);
`ifdef ARRAY_UPDATE_OOB_ERR_EN
        check("oob_src_sticky", CW'(oob_src), CW'(1));
`endif

        // Stall right after an accept: in-flight update lands, nothing new accepted.
        set_req(0, 32'd2, 33'h123);
        do_cycle();
        stall = 1'b1;
        req_valid = '1;
        do_cycle();
        check("stall_ready", CW'(req_ready), CW'(0));
        check("stall_arr", CW'(arr_out[2*EW +: EW]), CW'(33'h123));
        do_cycle();
        stall = 1'b0;
        req_valid = '0;
        do_cycle();

        // Reset while an update is in flight.
        set_req(3, 32'd0, 33'd99);
        do_cycle();
        req_valid = '0;
        rst = 1'b1;
        #1;
        check("rst_mid_upd_valid", CW'(upd_valid), CW'(0));
        check("rst_mid_arr", arr_out, '0);
        do_cycle();
        rst = 1'b0;
        do_cycle();
        check("rst_mid_no_land", arr_out, '0);

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            rst   = ($urandom_range(0, 99) == 0);
            stall = ($urandom_range(0, 9) == 0);
            for (int i = 0; i < NR; i++) begin
                r = $urandom_range(0, 9);
                req_valid[i] = ($urandom_range(0, 2) != 0);
                req_index[i*IW +: IW] = (r < 8) ? IW'(r % 5) : IW'($urandom);
                req_value[i*EW +: EW] = {1'($urandom_range(0, 1)), $urandom};
            end
            do_cycle();
        end
        rst = 1'b0; stall = 1'b0; req_valid = '0;
        do_cycle();
        do_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
